// File: rtl/levit_input_feeder.sv
// levit_input_feeder: buffers a 16 x NCOL pixel frame and a 3x3 weight file, then streams
// one column per cycle (with the first three weight taps) to the downstream accelerator.
module levit_input_feeder #(
    parameter int DATA_W = 8,
    parameter int NCOL   = 16,
    parameter int COL_AW = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [3:0]        wr_row,
    input  logic [COL_AW-1:0] wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic [DATA_W-1:0] i_r1,
    output logic [DATA_W-1:0] i_r2,
    output logic [DATA_W-1:0] i_r3,
    output logic [DATA_W-1:0] i_r4,
    output logic [DATA_W-1:0] i_r5,
    output logic [DATA_W-1:0] i_r6,
    output logic [DATA_W-1:0] i_r7,
    output logic [DATA_W-1:0] i_r8,
    output logic [DATA_W-1:0] i_r9,
    output logic [DATA_W-1:0] i_r10,
    output logic [DATA_W-1:0] i_r11,
    output logic [DATA_W-1:0] i_r12,
    output logic [DATA_W-1:0] i_r13,
    output logic [DATA_W-1:0] i_r14,
    output logic [DATA_W-1:0] i_r15,
    output logic [DATA_W-1:0] i_r16,
    output logic [DATA_W-1:0] conv16_f1,
    output logic [DATA_W-1:0] conv16_f2,
    output logic [DATA_W-1:0] conv16_f3,
    output logic              en,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(NCOL);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t            state, state_n;
    logic [COL_AW-1:0] col;
    logic              last_col;
    logic              pix_wr, wgt_wr;
    logic [DATA_W-1:0] pix [16][NCOL];
    logic [DATA_W-1:0] wgt [3][3];
    logic [DATA_W-1:0] row_d [16];
    logic [DATA_W-1:0] row_q [16];
    logic [DATA_W-1:0] f_d [3];
    logic [DATA_W-1:0] f_q [3];
    logic              en_d, busy_d, done_d;

    assign last_col = (col == COL_AW'(NCOL - 1));
    assign pix_wr   = rstn && state == IDLE && wr_en && !wr_sel && 32'(wr_col) < NCOL;
    assign wgt_wr   = rstn && state == IDLE && wr_en && wr_sel && wr_row < 4'd3 && wr_col < COL_AW'(3);

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = (state == IDLE)   ? (start ? STREAM : IDLE) :
                  (state == STREAM) ? (last_col ? DONE : STREAM) : IDLE;
    end

    always_comb begin
        en_d   = (state == STREAM);
        busy_d = (state != IDLE);
        done_d = (state == DONE);
        for (int r = 0; r < 16; r++)
            row_d[r] = en_d ? pix[r][col[CW-1:0]] : '0;
        for (int f = 0; f < 3; f++)
            f_d[f] = (en_d && col < COL_AW'(3)) ? wgt[f][col[1:0]] : '0;
    end

    // Counter idles at zero so it is already cleared on entry, and holds at the last column.
    always_ff @(posedge clk) begin
        if (!rstn || state != STREAM) col <= '0;
        else if (!last_col)           col <= col + 1'b1;
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (pix_wr) pix[wr_row][wr_col[CW-1:0]] <= wr_data;
        if (wgt_wr) wgt[wr_row[1:0]][wr_col[1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            en   <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            for (int r = 0; r < 16; r++) row_q[r] <= '0;
            for (int f = 0; f < 3; f++) f_q[f] <= '0;
        end else begin
            en   <= en_d;
            busy <= busy_d;
            done <= done_d;
            for (int r = 0; r < 16; r++) row_q[r] <= row_d[r];
            for (int f = 0; f < 3; f++) f_q[f] <= f_d[f];
        end
    end

    assign i_r1      = row_q[0];
    assign i_r2      = row_q[1];
    assign i_r3      = row_q[2];
    assign i_r4      = row_q[3];
    assign i_r5      = row_q[4];
    assign i_r6      = row_q[5];
    assign i_r7      = row_q[6];
    assign i_r8      = row_q[7];
    assign i_r9      = row_q[8];
    assign i_r10     = row_q[9];
    assign i_r11     = row_q[10];
    assign i_r12     = row_q[11];
    assign i_r13     = row_q[12];
    assign i_r14     = row_q[13];
    assign i_r15     = row_q[14];
    assign i_r16     = row_q[15];
    assign conv16_f1 = f_q[0];
    assign conv16_f2 = f_q[1];
    assign conv16_f3 = f_q[2];
endmodule

// File: tb/tb_levit_input_feeder.sv
// tb_levit_input_feeder: directed scenarios with random frame data, checked against
// a simple array model of the frame and weight contents.
module tb_levit_input_feeder;
    localparam int NCOL = 16;

    logic       clk = 1'b0;
    logic       rstn, wr_en, wr_sel, start;
    logic [3:0] wr_row;
    logic [7:0] wr_col, wr_data;
    logic [7:0] i_r1, i_r2, i_r3, i_r4, i_r5, i_r6, i_r7, i_r8;
    logic [7:0] i_r9, i_r10, i_r11, i_r12, i_r13, i_r14, i_r15, i_r16;
    logic [7:0] conv16_f1, conv16_f2, conv16_f3;
    logic       en, busy, done;
    logic [7:0] rows [16];
    logic [7:0] fo [3];

    logic [7:0] mpix [16][NCOL];
    logic [7:0] mw [3][3];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    levit_input_feeder dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .start(start),
        .i_r1(i_r1), .i_r2(i_r2), .i_r3(i_r3), .i_r4(i_r4), .i_r5(i_r5), .i_r6(i_r6),
        .i_r7(i_r7), .i_r8(i_r8), .i_r9(i_r9), .i_r10(i_r10), .i_r11(i_r11), .i_r12(i_r12),
        .i_r13(i_r13), .i_r14(i_r14), .i_r15(i_r15), .i_r16(i_r16),
        .conv16_f1(conv16_f1), .conv16_f2(conv16_f2), .conv16_f3(conv16_f3),
        .en(en), .busy(busy), .done(done)
    );

    assign rows[0] = i_r1;   assign rows[1] = i_r2;   assign rows[2] = i_r3;   assign rows[3] = i_r4;
    assign rows[4] = i_r5;   assign rows[5] = i_r6;   assign rows[6] = i_r7;   assign rows[7] = i_r8;
    assign rows[8] = i_r9;   assign rows[9] = i_r10;  assign rows[10] = i_r11; assign rows[11] = i_r12;
    assign rows[12] = i_r13; assign rows[13] = i_r14; assign rows[14] = i_r15; assign rows[15] = i_r16;
    assign fo[0] = conv16_f1; assign fo[1] = conv16_f2; assign fo[2] = conv16_f3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic all_quiet(input string tag, input logic exp_busy);
        chk({tag, " en"}, 32'(en), 0);
        chk({tag, " busy"}, 32'(busy), 32'(exp_busy));
        for (int r = 0; r < 16; r++) chk($sformatf("%s row%0d", tag, r), 32'(rows[r]), 0);
        for (int f = 0; f < 3; f++) chk($sformatf("%s f%0d", tag, f), 32'(fo[f]), 0);
    endtask

    // Writes while the feeder is idle update the model when the index is in range.
    task automatic do_write(input logic s, input logic [3:0] r, input logic [7:0] c, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = s; wr_row = r; wr_col = c; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (!s && c < NCOL) mpix[r][c] = d;
        if (s && r < 3 && c < 3) mw[r][c] = d;
    endtask

    task automatic start_edge(input logic hold);
        start = 1'b1;
        @(negedge clk);
        start = hold;
        chk("start-edge en", 32'(en), 0);
    endtask

    // Entered just after the edge that sampled start; ends just after the next IDLE edge.
    task automatic frame(input string tag, input int wr_at, input logic hold);
        for (int c = 0; c < NCOL; c++) begin
            if (c == wr_at) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 4'd0; wr_col = 8'd5; wr_data = 8'hFF;
            end
            @(negedge clk);
            wr_en = 1'b0;
            chk($sformatf("%s c%0d en", tag, c), 32'(en), 1);
            chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 1);
            chk($sformatf("%s c%0d done", tag, c), 32'(done), 0);
            for (int r = 0; r < 16; r++)
                chk($sformatf("%s c%0d row%0d", tag, c, r), 32'(rows[r]), 32'(mpix[r][c]));
            for (int f = 0; f < 3; f++)
                chk($sformatf("%s c%0d f%0d", tag, c, f), 32'(fo[f]), c < 3 ? 32'(mw[f][c]) : 0);
        end
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done), 1);
        all_quiet({tag, " done-cycle"}, 1'b1);
        @(negedge clk);
        start = hold;
        chk({tag, " done low"}, 32'(done), 0);
        all_quiet({tag, " idle-cycle"}, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        chk("reset done", 32'(done), 0);
        all_quiet("reset", 1'b0);
        rstn = 1'b1;

        for (int r = 0; r < 16; r++)
            for (int c = 0; c < NCOL; c++) do_write(1'b0, 4'(r), 8'(c), 8'(c + 1));
        for (int f = 0; f < 3; f++)
            for (int t = 0; t < 3; t++) do_write(1'b1, 4'(f), 8'(t), 8'(3 * f + t + 1));
        start_edge(1'b0);
        frame("single", -1, 1'b0);

        do_write(1'b0, 4'd0, 8'(NCOL), 8'hEE);
        do_write(1'b1, 4'd3, 8'd0, 8'hEE);
        do_write(1'b1, 4'd0, 8'd3, 8'hEE);
        start_edge(1'b0);
        frame("oor", -1, 1'b0);

        start_edge(1'b0);
        frame("lockout-wr", 2, 1'b0);
        start_edge(1'b0);
        frame("lockout-chk", -1, 1'b0);
        chk("lockout model", 32'(mpix[0][5]), 32'd6);

        for (int r = 0; r < 16; r++)
            for (int c = 0; c < NCOL; c++) do_write(1'b0, 4'(r), 8'(c), 8'($urandom_range(0, 255)));
        for (int f = 0; f < 3; f++)
            for (int t = 0; t < 3; t++) do_write(1'b1, 4'(f), 8'(t), 8'($urandom_range(1, 255)));

        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 4'd3; wr_col = 8'd0; wr_data = 8'h2A;
        mpix[3][0] = 8'h2A;
        start_edge(1'b0);
        wr_en = 1'b0;
        @(negedge clk);
        chk("simul i_r4", 32'(i_r4), 32'h2A);
        chk("simul en", 32'(en), 1);
        for (int c = 1; c < NCOL + 2; c++) @(negedge clk);
        chk("simul back idle", 32'(busy), 0);

        start_edge(1'b0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("pre-rst c%0d row0", c), 32'(rows[0]), 32'(mpix[0][c]));
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("midrst done", 32'(done), 0);
        all_quiet("midrst", 1'b0);
        for (int i = 0; i < NCOL + 4; i++) begin
            @(negedge clk);
            chk($sformatf("midrst after%0d done", i), 32'(done), 0);
            chk($sformatf("midrst after%0d en", i), 32'(en), 0);
        end
        start_edge(1'b0);
        frame("post-rst", -1, 1'b0);

        start_edge(1'b1);
        frame("b2b-1", -1, 1'b1);
        frame("b2b-2", -1, 1'b1);
        frame("b2b-3", -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
